sqrt_arbiter: RTL and testbench

SQRT_ARBITER -- requirements
Module: sqrt_arbiter

---
 rtl/sqrt_arbiter_if.sv | 25 ++
 rtl/sqrt_arbiter.sv | 132 +++++++++++++
 tb/tb_sqrt_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sqrt_arbiter_if.sv
// Request/result bundle between the requesters, the shared sqrt engine and the result consumer.
interface sqrt_arbiter_if #(
  parameter int inLen  = 32,
  parameter int numReq = 4,
  parameter int idLen  = 2
);
  logic [numReq-1:0]       req_valid;
  logic [numReq*inLen-1:0] req_data;
  logic [numReq-1:0]       req_ready;
  logic                    res_valid;
  logic [idLen-1:0]        res_id;
  logic [inLen/2-1:0]      res_q;
  logic [inLen/2:0]        res_r;
  logic                    res_ready;

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_q, res_r
  );

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_q, res_r
  );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter in front of one iterative non-restoring integer sqrt engine.
// One root digit per cycle; raw remainder is reported without correction.
module sqrt_arbiter #(
  parameter int inLen  = 32,
  parameter int numReq = 4,
  parameter int idLen  = 2
) (
  input  logic          clk,
  input  logic          rstn,
  sqrt_arbiter_if.slave bus,
  output logic          busy
);
  localparam int QW = inLen / 2;
  localparam int RW = QW + 1;
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  state_e             state_q;
  logic [idLen-1:0]   ptr_q, ptr_d;
  logic [idLen-1:0]   id_q;
  logic [inLen-1:0]   op_q;
  logic [RW-1:0]      r_q, r_sh, r_d;
  logic [QW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      cnt_q;
  logic               res_valid_q, busy_q;
  logic [idLen-1:0]   res_id_q;
  logic [QW-1:0]      res_q_q;
  logic [RW-1:0]      res_r_q;

  logic               gnt_vld;
  logic [idLen-1:0]   gnt_idx;
  logic [numReq-1:0]  ready;
  logic [inLen-1:0]   op_sel;
  int                 c;

  // First valid requester at or after ptr, wrapping
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    c       = 0;
    for (int k = 0; k < numReq; k++) begin
      c = int'(ptr_q) + k;
      if (c >= numReq) c = c - numReq;
      if (!gnt_vld && bus.req_valid[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = idLen'(c);
      end
    end
  end

  always_comb begin
    ready = '0;
    for (int k = 0; k < numReq; k++)
      ready[k] = rstn && (state_q == IDLE) && gnt_vld && (gnt_idx == idLen'(k));
  end

  always_comb begin
    if (int'(gnt_idx) == numReq - 1) ptr_d = '0;
    else                             ptr_d = gnt_idx + idLen'(1);
  end

  assign op_sel = bus.req_data[int'(gnt_idx)*inLen +: inLen];

  // q<<2 is formed in the root's own width before widening to the remainder width
  always_comb begin
    r_sh  = {r_q[RW-3:0], op_q[inLen-1 -: 2]};
    r_d   = r_q[RW-1] ? r_sh + RW'({acc_q[QW-3:0], 2'b11})
                      : r_sh - RW'({acc_q[QW-3:0], 2'b01});
    acc_d = {acc_q[QW-2:0], ~r_d[RW-1]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      op_q        <= '0;
      r_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      res_id_q    <= '0;
      res_q_q     <= '0;
      res_r_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            op_q    <= op_sel;
            id_q    <= gnt_idx;
            ptr_q   <= ptr_d;
            r_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= CW'(QW - 1);
            busy_q  <= 1'b1;
            state_q <= ITER;
          end
        end
        ITER: begin
          r_q   <= r_d;
          acc_q <= acc_d;
          op_q  <= op_q << 2;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q     <= DONE;
            res_valid_q <= 1'b1;
            res_q_q     <= acc_d;
            res_r_q     <= r_d;
            res_id_q    <= id_q;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_q     = res_q_q;
  assign bus.res_r     = res_r_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench: hand-computed sqrt vectors, round-robin order, result hold and mid-op reset.
module tb_sqrt_arbiter;
  localparam int IN = 32, NR = 4, IDL = 2, QW = 16, RW = 17;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  sqrt_arbiter_if #(.inLen(IN), .numReq(NR), .idLen(IDL)) bus();

  sqrt_arbiter #(.inLen(IN), .numReq(NR), .idLen(IDL)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .busy(busy)
  );

  int n_cmp = 0, n_err = 0;
  int cyc = 0, rdy_cnt = 0;
  int g_ids[$], g_cyc[$], r_ids[$], r_cyc[$];
  logic [QW-1:0] r_qv[$];
  logic [RW-1:0] r_rv[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshake log, sampled on the active edge before the DUT updates
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rstn) begin
      if (|bus.req_ready) rdy_cnt++;
      for (int k = 0; k < NR; k++)
        if (bus.req_valid[k] && bus.req_ready[k]) begin
          g_ids.push_back(k);
          g_cyc.push_back(cyc);
        end
      if (bus.res_valid && bus.res_ready) begin
        r_ids.push_back(int'(bus.res_id));
        r_qv.push_back(bus.res_q);
        r_rv.push_back(bus.res_r);
        r_cyc.push_back(cyc);
      end
    end
  end

  task automatic set_req(input int id, input logic [IN-1:0] d);
    bus.req_valid[id]            = 1'b1;
    bus.req_data[id*IN +: IN]    = d;
  endtask

  task automatic run_one(input string tag, input int id, input logic [IN-1:0] d,
                         input logic [QW-1:0] eq, input logic [RW-1:0] er);
    int n0, ng;
    n0 = r_ids.size();
    ng = g_ids.size();
    @(negedge clk);
    bus.req_valid = '0;
    set_req(id, d);
    bus.res_ready = 1'b1;
    #1 chk({tag, "_ready"}, bus.req_ready, 4'b0001 << id);
    for (int t = 0; t < 60 && r_ids.size() == n0; t++) begin
      @(negedge clk);
      if (g_ids.size() > ng) bus.req_valid[id] = 1'b0;
    end
    if (r_ids.size() == n0 || g_ids.size() == ng) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_gnt"}, g_ids[$], id);
      chk({tag, "_id"},  r_ids[$], id);
      chk({tag, "_q"},   r_qv[$], eq);
      chk({tag, "_r"},   r_rv[$], er);
      chk({tag, "_lat"}, r_cyc[$] - g_cyc[$], 17);
    end
  endtask

  initial begin
    int nr, ng, rdy0, t;
    logic [QW-1:0] exq[4];
    logic [RW-1:0] exr[4];
    exq = '{16'h0000, 16'h0004, 16'hFFFF, 16'h0001};
    exr = '{17'h1FFFF, 17'h1FFF7, 17'h0FFFE, 17'h00001};
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;

    // Reset state, with requests pending
    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_busy",  busy, 0);
    chk("rst_rv",    bus.res_valid, 0);
    chk("rst_q",     bus.res_q, 0);
    chk("rst_r",     bus.res_r, 0);
    chk("rst_id",    bus.res_id, 0);
    chk("rst_ready", bus.req_ready, 0);
    @(negedge clk);
    bus.req_valid = '0;
    rstn = 1'b1;

    run_one("in0",   0, 32'h0000_0000, 16'h0000, 17'h1FFFF);
    run_one("in16",  1, 32'h0000_0010, 16'h0004, 17'h1FFF7);
    run_one("inmax", 2, 32'hFFFF_FFFF, 16'hFFFF, 17'h0FFFE);
    run_one("in2",   3, 32'h0000_0002, 16'h0001, 17'h00001);

    // Consumer stalls in DONE while requester 1 waits
    @(negedge clk);
    bus.req_valid = '0;
    set_req(0, 32'd4);
    bus.res_ready = 1'b0;
    ng = g_ids.size();
    for (t = 0; t < 60 && !bus.res_valid; t++) begin
      @(negedge clk);
      if (g_ids.size() > ng && bus.req_valid[0]) begin
        bus.req_valid[0] = 1'b0;
        set_req(1, 32'd16);
      end
    end
    if (!bus.res_valid) chk("hold_timeout", 0, 1);
    for (int k = 0; k < 5; k++) begin
      chk("hold_rv",    bus.res_valid, 1);
      chk("hold_busy",  busy, 1);
      chk("hold_q",     bus.res_q, 16'h0002);
      chk("hold_r",     bus.res_r, 17'h1FFFB);
      chk("hold_id",    bus.res_id, 0);
      chk("hold_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("rel_rv",    bus.res_valid, 0);
    chk("rel_busy",  busy, 0);
    chk("rel_ready", bus.req_ready, 4'b0010);

    // Abort requester 1 at ITER cycle 8; ptr would otherwise point at 2
    nr = r_ids.size();
    repeat (8) @(negedge clk);
    chk("iter_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("abort_busy",  busy, 0);
    chk("abort_rv",    bus.res_valid, 0);
    chk("abort_ready", bus.req_ready, 0);
    chk("abort_q",     bus.res_q, 0);
    bus.req_valid = '0;
    set_req(0, 32'h0000_0000);
    set_req(1, 32'h0000_0010);
    set_req(2, 32'hFFFF_FFFF);
    set_req(3, 32'h0000_0002);
    repeat (2) @(negedge clk);
    rdy0 = rdy_cnt;
    ng   = g_ids.size();
    rstn = 1'b1;
    #1 chk("post_rst_ready", bus.req_ready, 4'b0001);

    // All requesters stay valid: expect 0,1,2,3,0 at 18-cycle spacing
    for (t = 0; t < 200 && g_ids.size() < ng + 5; t++) @(negedge clk);
    chk("abort_nores", r_ids.size() >= nr + 1 ? r_ids[nr] : 9, 0);
    if (g_ids.size() < ng + 5) chk("rr_timeout", 0, 1);
    else begin
      for (int k = 0; k < 5; k++) chk($sformatf("rr_id%0d", k), g_ids[ng+k], k % 4);
      for (int k = 1; k < 5; k++) chk($sformatf("rr_gap%0d", k), g_cyc[ng+k] - g_cyc[ng+k-1], 18);
      chk("rr_pulses", rdy_cnt - rdy0, 5);
      chk("rr_nres", r_ids.size() - nr, 4);
      for (int k = 0; k < 4 && nr + k < r_ids.size(); k++) begin
        chk($sformatf("rr_rid%0d", k), r_ids[nr+k], k);
        chk($sformatf("rr_q%0d", k),   r_qv[nr+k], exq[k]);
        chk($sformatf("rr_r%0d", k),   r_rv[nr+k], exr[k]);
      end
    end
    bus.req_valid = '0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
